// File: rtl/gpu_rect_renderer.sv
// rtl/gpu_rect_renderer.sv - frame renderer: background clear followed by one clipped rectangle fill
//
// Purpose:
//   Each accepted frame request writes the whole back buffer with the
//   background shade. It then writes one axis-aligned rectangle with the
//   foreground shade. One pixel is written per clock and there are no gap
//   cycles between the clear and the fill.
//
// Ports:
//   clk                 GPU / frame-buffer write clock
//   reset               synchronous reset, active-low
//   gpu_start           frame request level from the frame buffer
//   cmd_x0, cmd_y0      rectangle top-left corner (inclusive)
//   cmd_x1, cmd_y1      rectangle bottom-right corner (inclusive)
//   cmd_color           rectangle grey level
//   cmd_bg              background clear grey level
//   gpu_x, gpu_y        current pixel coordinate (registered)
//   gpu_data            current pixel value (registered)
//   gpu_we              write strobe, one pixel per cycle while high
//   gpu_done            high when idle, low while rendering
module gpu_rect_renderer #(
  parameter int H_RES = 320,
  parameter int V_RES = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gpu_start,
  input  logic [9:0] cmd_x0,
  input  logic [9:0] cmd_y0,
  input  logic [9:0] cmd_x1,
  input  logic [9:0] cmd_y1,
  input  logic [3:0] cmd_color,
  input  logic [3:0] cmd_bg,
  output logic [9:0] gpu_x,
  output logic [9:0] gpu_y,
  output logic [3:0] gpu_data,
  output logic       gpu_we,
  output logic       gpu_done
);

  localparam logic [9:0] X_LAST = 10'(H_RES - 1);
  localparam logic [9:0] Y_LAST = 10'(V_RES - 1);
  localparam logic [9:0] X_SIZE = 10'(H_RES);
  localparam logic [9:0] Y_SIZE = 10'(V_RES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_FILL  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [9:0] r_x;
  logic [9:0] r_y;
  logic [3:0] r_data;
  logic       r_we;
  logic       r_done;

  logic [9:0] w_x_nxt;
  logic [9:0] w_y_nxt;
  logic [3:0] w_data_nxt;
  logic       w_we_nxt;
  logic       w_done_nxt;
  logic       w_latch;

  // Frame command captured on the accept cycle; later cmd_* changes are ignored.
  logic [9:0] r_x0;
  logic [9:0] r_y0;
  logic [9:0] r_ex;
  logic [9:0] r_ey;
  logic [3:0] r_color;
  logic       r_fill_empty;

  // Clipped far corner and emptiness, evaluated on the raw command inputs.
  logic [9:0] w_ex;
  logic [9:0] w_ey;
  logic       w_fill_empty;

  assign w_ex = (cmd_x1 > X_LAST) ? X_LAST : cmd_x1;
  assign w_ey = (cmd_y1 > Y_LAST) ? Y_LAST : cmd_y1;
  assign w_fill_empty = (cmd_x0 > w_ex) || (cmd_y0 > w_ey) ||
                        (cmd_x0 >= X_SIZE) || (cmd_y0 >= Y_SIZE);

  assign gpu_x    = r_x;
  assign gpu_y    = r_y;
  assign gpu_data = r_data;
  assign gpu_we   = r_we;
  assign gpu_done = r_done;

  // Next-state and next-output logic. The outputs are registered, so each
  // branch computes the pixel that the next cycle presents. Coordinates and
  // data hold by default, which keeps the last pixel visible after completion.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_data_nxt  = r_data;
    w_we_nxt    = 1'b0;
    w_done_nxt  = 1'b1;
    w_latch     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (gpu_start) begin
          w_latch     = 1'b1;
          w_state_nxt = S_CLEAR;
          w_x_nxt     = 10'd0;
          w_y_nxt     = 10'd0;
          w_data_nxt  = cmd_bg;
          w_we_nxt    = 1'b1;
          w_done_nxt  = 1'b0;
        end
      end

      S_CLEAR: begin
        w_we_nxt   = 1'b1;
        w_done_nxt = 1'b0;
        if (r_x != X_LAST) begin
          w_x_nxt = r_x + 10'd1;
        end else if (r_y != Y_LAST) begin
          w_x_nxt = 10'd0;
          w_y_nxt = r_y + 10'd1;
        end else if (r_fill_empty) begin
          w_state_nxt = S_IDLE;
          w_we_nxt    = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          // The last clear pixel hands off directly to the first fill pixel.
          w_state_nxt = S_FILL;
          w_x_nxt     = r_x0;
          w_y_nxt     = r_y0;
          w_data_nxt  = r_color;
        end
      end

      S_FILL: begin
        w_we_nxt   = 1'b1;
        w_done_nxt = 1'b0;
        if (r_x != r_ex) begin
          w_x_nxt = r_x + 10'd1;
        end else if (r_y != r_ey) begin
          w_x_nxt = r_x0;
          w_y_nxt = r_y + 10'd1;
        end else begin
          w_state_nxt = S_IDLE;
          w_we_nxt    = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_x     <= 10'd0;
      r_y     <= 10'd0;
      r_data  <= 4'd0;
      r_we    <= 1'b0;
      r_done  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_data  <= w_data_nxt;
      r_we    <= w_we_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_x0         <= 10'd0;
      r_y0         <= 10'd0;
      r_ex         <= 10'd0;
      r_ey         <= 10'd0;
      r_color      <= 4'd0;
      r_fill_empty <= 1'b1;
    end else if (w_latch) begin
      r_x0         <= cmd_x0;
      r_y0         <= cmd_y0;
      r_ex         <= w_ex;
      r_ey         <= w_ey;
      r_color      <= cmd_color;
      r_fill_empty <= w_fill_empty;
    end
  end

endmodule
